scaled_frame_reader: RTL
========================

# scaled_frame_reader

Parametrised frame buffer with integrated banked storage and an integer-upscaling raster reader. A writer (camera/convolution side) fills a SRC_COLS×SRC_ROWS image; the reader streams it out at (SRC_COLS<<SCALE_SHIFT)×(SRC_ROWS<<SCALE_SHIFT) through a valid/ready handshake with start-of-frame, end-of-line and end-of-frame tags. Optional per-frame horizontal and vertical mirroring. Sits between the capture/filter path and the VGA output stage, replacing the fixed 320×240→640×480 buffer.

## Interface
- DATA_W, 12, pixel width
- SRC_COLS, 320, source image width
- SRC_ROWS, 240, source image height
- SCALE_SHIFT, 1, output = source × 2^SCALE_SHIFT in each axis (0..3)
- BANK_DEPTH, 65536, words per RAM bank, power of two
- ADDR_W, 17, write-address width, ≥ clog2(SRC_COLS*SRC_ROWS)
- clk  in  1  single clock for both ports
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  linear source address, row-major (y*SRC_COLS + x)
- wr_data  in  DATA_W  pixel to write
- wr_err  out  1  one-cycle pulse: write ignored, address out of range
- run  in  1  level; enables frame output
- hflip  in  1  mirror horizontally; sampled at frame start
- vflip  in  1  mirror vertically; sampled at frame start
- out_valid  out  1  output pixel valid
- out_ready  in  1  consumer accepts pixel
- out_data  out  DATA_W  pixel
- out_sof  out  1  tags output pixel (0,0)
- out_eol  out  1  tags last pixel of each output line
- out_eof  out  1  tags last pixel of frame
- frame_done  out  1  one-cycle pulse when the out_eof pixel is accepted
- busy  out  1  FSM not IDLE

## Operation
- Storage: NUM_BANKS = ceil(SRC_COLS*SRC_ROWS / BANK_DEPTH) banks; bank = addr / BANK_DEPTH, offset = addr % BANK_DEPTH. Write decodes bank from wr_addr; read mux selects bank using the bank index delayed to match RAM latency (1 cycle, registered read, clock-enabled).
- wr_addr ≥ SRC_COLS*SRC_ROWS: no bank written, wr_err pulses next cycle.
- Read/write same address same cycle: read returns old data.
- Output counters x_out in 0..OUT_COLS-1, y_out in 0..OUT_ROWS-1 (OUT_* = SRC_* << SCALE_SHIFT). sx = x_out >> SCALE_SHIFT, sy = y_out >> SCALE_SHIFT; if hflip_q, sx = SRC_COLS-1-sx; if vflip_q, sy = SRC_ROWS-1-sy. Read addr = sy*SRC_COLS + sx, computed at full ADDR_W width, no truncation.
- FSM: IDLE → ACTIVE when run=1 (latch hflip/vflip, zero counters). ACTIVE issues one address per advance; after issuing the last address → FLUSH. FLUSH → IDLE when the eof pixel is accepted, or → ACTIVE directly (new flips latched) if run=1 at that acceptance.
- run deasserted mid-frame: current frame completes; no new frame starts.
- Tags travel with the pixel through the pipeline; a pixel with sof may also carry eol only if OUT_COLS=1.

## Timing
- Pipeline: S0 address register → S1 RAM/bank mux → S2 output register. Global advance = !out_valid || out_ready; all three stages, counters and RAM read-enable stall together.
- Latency: first out_valid 3 cycles after the cycle run is seen high in IDLE with out_ready=1.
- With out_ready held high: one pixel per cycle, OUT_COLS*OUT_ROWS consecutive valid cycles per frame, no bubbles between back-to-back frames.
- out_data/tags stable while out_valid=1 and out_ready=0.
- Reset values: out_valid 0, out_data 0, out_sof/eol/eof 0, frame_done 0, wr_err 0, busy 0, FSM IDLE, counters 0. Reset mid-frame aborts immediately; RAM contents undefined-preserved (not cleared).

## Test plan
- SRC 4×2, SCALE_SHIFT 1, RAM filled with addr value, run=1, out_ready=1 → 32 pixels, line 0 = 0,0,1,1,2,2,3,3; line 1 repeats line 0; line 2 = 4,4,5,5,6,6,7,7; sof on pixel 0, eol every 8th, eof + frame_done on pixel 31.
- Same, hflip=1 vflip=1 → first line 7,7,6,6,5,5,4,4, last line 3,3,2,2,1,1,0,0; flips toggled mid-frame have no effect until next frame.
- Random out_ready (50%) → sequence identical to case 1, data held stable while stalled, no loss/duplication.
- SRC 320×240, BANK_DEPTH 65536: write 0xABC at addr 65535, 0x123 at 65536 → reads return each correctly across bank boundary; write addr 76800 → wr_err pulse, no RAM change.
- run deasserted at pixel 10 → frame completes to eof, busy drops, out_valid stays 0; run held → next sof immediately follows eof.
- rst asserted mid-frame with out_valid=1 → all outputs 0 at once; after release with run=1, frame restarts at pixel (0,0) with sof.

Source files
------------

// File: rtl/scaled_frame_reader.sv
// Banked frame buffer with an integer-upscaling raster reader.
// The writer fills SRC_COLS x SRC_ROWS; the reader streams the scaled frame over valid/ready.
module scaled_frame_reader #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SRC_COLS    = 320,
  parameter int unsigned SRC_ROWS    = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned BANK_DEPTH  = 65536,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_err,
  input  logic              i_run,
  input  logic              i_hflip,
  input  logic              i_vflip,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_sof,
  output logic              o_out_eol,
  output logic              o_out_eof,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int unsigned TOTAL     = SRC_COLS * SRC_ROWS;
  localparam int unsigned NUM_BANKS = (TOTAL + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int unsigned BANK_AW   = $clog2(BANK_DEPTH);
  localparam int unsigned OUT_COLS  = SRC_COLS << SCALE_SHIFT;
  localparam int unsigned OUT_ROWS  = SRC_ROWS << SCALE_SHIFT;
  localparam int unsigned XW        = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int unsigned YW        = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e            r_state, w_state_next;
  logic [XW-1:0]     r_x, w_x_cur, w_x_next;
  logic [YW-1:0]     r_y, w_y_cur, w_y_next;
  logic              r_hflip, r_vflip, w_hflip_cur, w_vflip_cur, w_hflip_next, w_vflip_next;
  logic              w_advance, w_eof_accept, w_start, w_issue;
  logic              w_last_x, w_last_y, w_first;
  logic [ADDR_W-1:0] w_sx, w_sy, w_rd_addr;

  logic              r_s0_valid, r_s0_sof, r_s0_eol, r_s0_eof;
  logic [ADDR_W-1:0] r_s0_addr;
  logic              r_s1_valid, r_s1_sof, r_s1_eol, r_s1_eof;
  logic [ADDR_W-1:0] r_s1_bank;
  logic              r_out_valid, r_out_sof, r_out_eol, r_out_eof;
  logic [DATA_W-1:0] r_out_data;
  logic              r_wr_err;

  logic               w_wr_ok;
  logic [ADDR_W-1:0]  w_wr_bank;
  logic [BANK_AW-1:0] w_wr_off, w_rd_off;
  logic [DATA_W-1:0]  w_bank_rd [NUM_BANKS];
  logic [DATA_W-1:0]  w_rd_data;

  assign w_advance    = !r_out_valid || i_out_ready;
  assign w_eof_accept = r_out_valid && i_out_ready && r_out_eof;

  // A frame start issues pixel (0,0) in the same cycle, using the live flip inputs.
  always_comb begin
    w_start = w_advance && i_run &&
              ((r_state == StIdle) || ((r_state == StFlush) && w_eof_accept));
    w_issue     = w_start || (w_advance && (r_state == StActive));
    w_x_cur     = w_start ? '0 : r_x;
    w_y_cur     = w_start ? '0 : r_y;
    w_hflip_cur = w_start ? i_hflip : r_hflip;
    w_vflip_cur = w_start ? i_vflip : r_vflip;
    w_last_x    = (w_x_cur == XW'(OUT_COLS - 1));
    w_last_y    = (w_y_cur == YW'(OUT_ROWS - 1));
    w_first     = (w_x_cur == '0) && (w_y_cur == '0);
    w_sx        = ADDR_W'(w_x_cur >> SCALE_SHIFT);
    w_sy        = ADDR_W'(w_y_cur >> SCALE_SHIFT);
    if (w_hflip_cur) w_sx = ADDR_W'(SRC_COLS - 1) - w_sx;
    if (w_vflip_cur) w_sy = ADDR_W'(SRC_ROWS - 1) - w_sy;
    w_rd_addr = (w_sy * ADDR_W'(SRC_COLS)) + w_sx;
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_hflip_next = r_hflip;
    w_vflip_next = r_vflip;
    if (w_issue) begin
      w_state_next = StActive;
      w_hflip_next = w_hflip_cur;
      w_vflip_next = w_vflip_cur;
      w_y_next     = w_y_cur;
      if (!w_last_x) begin
        w_x_next = w_x_cur + XW'(1);
      end else begin
        w_x_next = '0;
        w_y_next = w_last_y ? '0 : w_y_cur + YW'(1);
      end
      // Wrapping straight into the next frame keeps the output free of bubbles.
      if (w_last_x && w_last_y) begin
        if (i_run) begin
          w_hflip_next = i_hflip;
          w_vflip_next = i_vflip;
        end else begin
          w_state_next = StFlush;
        end
      end
    end else if ((r_state == StFlush) && w_eof_accept) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_hflip <= 1'b0;
      r_vflip <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hflip <= w_hflip_next;
      r_vflip <= w_vflip_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0_valid <= 1'b0;
      r_s0_addr  <= '0;
      r_s0_sof   <= 1'b0;
      r_s0_eol   <= 1'b0;
      r_s0_eof   <= 1'b0;
    end else if (w_advance) begin
      r_s0_valid <= w_issue;
      r_s0_addr  <= w_rd_addr;
      r_s0_sof   <= w_issue && w_first;
      r_s0_eol   <= w_issue && w_last_x;
      r_s0_eof   <= w_issue && w_last_x && w_last_y;
    end
  end

  assign w_wr_ok   = {1'b0, i_wr_addr} < TOTAL_W;
  assign w_wr_bank = i_wr_addr >> BANK_AW;
  assign w_wr_off  = BANK_AW'(i_wr_addr);
  assign w_rd_off  = BANK_AW'(r_s0_addr);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [BANK_DEPTH];
    logic [DATA_W-1:0] r_rd;
    logic              w_we;

    assign w_we = i_wr_en && w_wr_ok && (w_wr_bank == ADDR_W'(b));

    // Non-blocking read and write give read-old-data on a same-address collision.
    always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_wr_off] <= i_wr_data;
      if (w_advance) r_rd <= r_mem[w_rd_off];
    end

    assign w_bank_rd[b] = r_rd;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_bank  <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= r_s0_valid;
      r_s1_bank  <= r_s0_addr >> BANK_AW;
      r_s1_sof   <= r_s0_sof;
      r_s1_eol   <= r_s0_eol;
      r_s1_eof   <= r_s0_eof;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_s1_bank == ADDR_W'(b)) w_rd_data = w_bank_rd[b];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_rd_data;
      r_out_sof   <= r_s1_sof;
      r_out_eol   <= r_s1_eol;
      r_out_eof   <= r_s1_eof;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && !w_wr_ok;
    end
  end

  assign o_wr_err     = r_wr_err;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_sof    = r_out_sof;
  assign o_out_eol    = r_out_eol;
  assign o_out_eof    = r_out_eof;
  assign o_frame_done = w_eof_accept;
  assign o_busy       = (r_state != StIdle);

endmodule
